// File: rtl/maze_tile_scanner_if.sv
// Pixel-side bundle between the VGA timing generator, the maze map RAM,
// the tile graphic ROMs and the tile scanner.
interface maze_tile_scanner_if #(
  parameter int REL_BITS         = 7,
  parameter int PIXEL_COLOR_BITS = 8,
  parameter int ADDR_BITS        = 6
);
  logic                        pix_en;
  logic [9:0]                  hcount;
  logic [9:0]                  vcount;
  logic [ADDR_BITS-1:0]        map_addr;
  logic [1:0]                  map_data;
  logic [REL_BITS-1:0]         rel_x;
  logic [REL_BITS-1:0]         rel_y;
  logic [PIXEL_COLOR_BITS-1:0] wall_pixel;
  logic [PIXEL_COLOR_BITS-1:0] pellet_pixel;
  logic [PIXEL_COLOR_BITS-1:0] pixel_out;
  logic                        pixel_valid;

  // Environment side: timing generator, map RAM and graphic ROMs.
  modport master (
    output pix_en, hcount, vcount, map_data, wall_pixel, pellet_pixel,
    input  map_addr, rel_x, rel_y, pixel_out, pixel_valid
  );

  // Scanner side.
  modport slave (
    input  pix_en, hcount, vcount, map_data, wall_pixel, pellet_pixel,
    output map_addr, rel_x, rel_y, pixel_out, pixel_valid
  );
endinterface

// File: rtl/maze_tile_scanner.sv
// Scan-order tile addresser and compositor: incremental tile/offset trackers,
// 3-stage pipeline (map address, ROM offsets + tile type, registered colour).
module maze_tile_scanner #(
  parameter int PIXELS_WIDTH     = 80,
  parameter int REL_BITS         = 7,
  parameter int PIXEL_COLOR_BITS = 8,
  parameter int MAP_COLS         = 8,
  parameter int MAP_ROWS         = 6,
  parameter int ADDR_BITS        = 6,
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480
) (
  input  logic               clk,
  input  logic               rst,
  maze_tile_scanner_if.slave bus
);
  localparam int COL_BITS = $clog2(MAP_COLS + 1);
  localparam int ROW_BITS = $clog2(MAP_ROWS + 1);

  localparam logic [9:0]          H_END   = 10'(H_ACTIVE);
  localparam logic [9:0]          H_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0]          V_END   = 10'(V_ACTIVE);
  localparam logic [REL_BITS-1:0] OFF_LAST = REL_BITS'(PIXELS_WIDTH - 1);
  localparam logic [COL_BITS-1:0] COL_LIM = COL_BITS'(MAP_COLS);
  localparam logic [ROW_BITS-1:0] ROW_LIM = ROW_BITS'(MAP_ROWS);
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(MAP_COLS);

  // Trackers
  logic [REL_BITS-1:0]  x_off_reg, y_off_reg;
  logic [COL_BITS-1:0]  col_reg;
  logic [ROW_BITS-1:0]  row_reg;
  logic [ADDR_BITS-1:0] row_base_reg;
  logic                 frame_locked_reg;

  // Pipeline
  logic                        s1_active_reg, s1_oob_reg;
  logic [REL_BITS-1:0]         s1_x_reg, s1_y_reg;
  logic [ADDR_BITS-1:0]        map_addr_reg;
  logic                        s2_active_reg, s2_oob_reg;
  logic [REL_BITS-1:0]         rel_x_reg, rel_y_reg;
  logic [PIXEL_COLOR_BITS-1:0] pixel_out_reg;
  logic                        pixel_valid_reg;

  logic                        frame_start, line_end, cap_active, cap_oob;
  logic [REL_BITS-1:0]         cap_x, cap_y;
  logic [COL_BITS-1:0]         cap_col;
  logic [ROW_BITS-1:0]         cap_row;
  logic [ADDR_BITS-1:0]        cap_base;
  logic [PIXEL_COLOR_BITS-1:0] pixel_next;

  always_comb begin
    frame_start = bus.pix_en && (bus.hcount == 10'd0) && (bus.vcount == 10'd0);
    line_end    = bus.pix_en && (bus.hcount == H_LAST) && (bus.vcount < V_END);
    cap_x       = (bus.hcount == 10'd0) ? '0 : x_off_reg;
    cap_col     = (bus.hcount == 10'd0) ? '0 : col_reg;
    cap_y       = frame_start ? '0 : y_off_reg;
    cap_row     = frame_start ? '0 : row_reg;
    cap_base    = frame_start ? '0 : row_base_reg;
    cap_active  = bus.pix_en && (bus.hcount < H_END) && (bus.vcount < V_END) &&
                  (frame_locked_reg || frame_start);
    cap_oob     = (cap_col >= COL_LIM) || (cap_row >= ROW_LIM);
  end

  // map_data is the tile type for the address issued in the previous cycle.
  always_comb begin
    pixel_next = '0;
    if (s2_active_reg && !s2_oob_reg) begin
      case (bus.map_data)
        2'd1:    pixel_next = bus.wall_pixel;
        2'd2:    pixel_next = bus.pellet_pixel;
        default: pixel_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_off_reg        <= '0;
      col_reg          <= '0;
      y_off_reg        <= '0;
      row_reg          <= '0;
      row_base_reg     <= '0;
      frame_locked_reg <= 1'b0;
    end else begin
      if (bus.pix_en) begin
        if (cap_active && cap_x == OFF_LAST) begin
          x_off_reg <= '0;
          col_reg   <= (cap_col == COL_LIM) ? cap_col : cap_col + 1'b1;
        end else begin
          x_off_reg <= cap_active ? cap_x + 1'b1 : cap_x;
          col_reg   <= cap_col;
        end
      end
      // hcount==0 and hcount==H_ACTIVE-1 never coincide, so these are exclusive.
      if (frame_start) begin
        y_off_reg        <= '0;
        row_reg          <= '0;
        row_base_reg     <= '0;
        frame_locked_reg <= 1'b1;
      end else if (line_end) begin
        if (y_off_reg == OFF_LAST) begin
          y_off_reg <= '0;
          if (row_reg != ROW_LIM) begin
            row_reg      <= row_reg + 1'b1;
            row_base_reg <= row_base_reg + ROW_STEP;
          end
        end else begin
          y_off_reg <= y_off_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active_reg   <= 1'b0;
      s1_oob_reg      <= 1'b0;
      s1_x_reg        <= '0;
      s1_y_reg        <= '0;
      map_addr_reg    <= '0;
      s2_active_reg   <= 1'b0;
      s2_oob_reg      <= 1'b0;
      rel_x_reg       <= '0;
      rel_y_reg       <= '0;
      pixel_out_reg   <= '0;
      pixel_valid_reg <= 1'b0;
    end else begin
      s1_active_reg   <= cap_active;
      s1_oob_reg      <= cap_oob;
      s1_x_reg        <= cap_x;
      s1_y_reg        <= cap_y;
      map_addr_reg    <= (cap_active && !cap_oob) ? cap_base + ADDR_BITS'(cap_col) : '0;
      s2_active_reg   <= s1_active_reg;
      s2_oob_reg      <= s1_oob_reg;
      rel_x_reg       <= s1_x_reg;
      rel_y_reg       <= s1_y_reg;
      pixel_out_reg   <= pixel_next;
      pixel_valid_reg <= s2_active_reg;
    end
  end

  assign bus.map_addr    = map_addr_reg;
  assign bus.rel_x       = rel_x_reg;
  assign bus.rel_y       = rel_y_reg;
  assign bus.pixel_out   = pixel_out_reg;
  assign bus.pixel_valid = pixel_valid_reg;
endmodule

// File: tb/tb_maze_tile_scanner.sv
// Randomized bench for maze_tile_scanner: scan-order model built from pixel and
// line counts, with a registered map RAM and combinational graphic ROMs.
module tb_maze_tile_scanner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_tile_scanner_if bus ();

  maze_tile_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0] map_mem [0:63];

  function automatic logic [7:0] wall_fn(input int x, input int y);
    logic [6:0] xv, yv;
    xv = 7'(x);
    yv = 7'(y);
    return {2'b11, xv[2:0], yv[2:0]};
  endfunction

  function automatic logic [7:0] pellet_fn(input int x, input int y);
    logic [6:0] xv, yv;
    xv = 7'(x);
    yv = 7'(y);
    return 8'hFF ^ {1'b0, xv[3:0], yv[2:0]};
  endfunction

  always_ff @(posedge clk) bus.map_data <= map_mem[bus.map_addr];
  assign bus.wall_pixel   = wall_fn(int'(bus.rel_x), int'(bus.rel_y));
  assign bus.pellet_pixel = pellet_fn(int'(bus.rel_x), int'(bus.rel_y));

  int checks = 0;
  int passes = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  typedef struct {
    bit act;
    bit oob;
    bit rst_zero;
    int addr;
    int x;
    int y;
  } ent_t;

  ent_t e1, e2, e3;
  bit   locked;
  int   k_pix;   // active pixels captured since the start of the line
  int   r_line;  // line ends seen since the start of the frame

  // Drive one clock worth of inputs, advance the model, then check all outputs.
  task automatic step(input bit pe, input int h, input int v, input bit r_in);
    ent_t e;
    ent_t z;
    bit   ls;
    int   col, row, t;
    logic [7:0] exp_pix;
    e = '{default: 0};
    z = '{default: 0};
    z.rst_zero = 1'b1;
    bus.pix_en = pe;
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
    rst = r_in;
    if (pe && !r_in) begin
      ls = (h == 0 && v == 0);
      if (ls) r_line = 0;
      if (h == 0) k_pix = 0;
      e.act = (h < 640) && (v < 480) && (locked || ls);
      if (ls) locked = 1'b1;
      col = k_pix / 80;
      if (col > 8) col = 8;
      row = r_line / 80;
      if (row > 6) row = 6;
      e.x = k_pix % 80;
      e.y = r_line % 80;
      e.oob = (col >= 8) || (row >= 6);
      e.addr = (e.act && !e.oob) ? row * 8 + col : 0;
      if (e.act) k_pix++;
      if (h == 639 && v < 480) r_line++;
    end
    @(posedge clk);
    #1;
    if (r_in) begin
      locked = 1'b0;
      k_pix = 0;
      r_line = 0;
      e1 = z;
      e2 = z;
      e3 = z;
    end else begin
      e3 = e2;
      e2 = e1;
      e1 = e;
    end
    check_val("map_addr", 32'(bus.map_addr), 32'(e1.addr));
    if (e2.act || e2.rst_zero) begin
      check_val("rel_x", 32'(bus.rel_x), 32'(e2.x));
      check_val("rel_y", 32'(bus.rel_y), 32'(e2.y));
    end
    check_val("pixel_valid", 32'(bus.pixel_valid), 32'(e3.act));
    exp_pix = 8'h00;
    if (e3.act && !e3.oob) begin
      t = int'(map_mem[e3.addr]);
      if (t == 1) exp_pix = wall_fn(e3.x, e3.y);
      else if (t == 2) exp_pix = pellet_fn(e3.x, e3.y);
    end
    check_val("pixel_out", 32'(bus.pixel_out), 32'(exp_pix));
  endtask

  task automatic idle_gap();
    if ($urandom_range(0, 3) == 0) begin
      int n;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
    end
  endtask

  task automatic scan_line(input int v, input bit full);
    if (full) begin
      for (int h = 0; h < 640; h++) begin
        idle_gap();
        step(1'b1, h, v, 1'b0);
      end
    end else begin
      step(1'b1, 0, v, 1'b0);
      idle_gap();
      step(1'b1, 639, v, 1'b0);
    end
    step(1'b1, 700, v, 1'b0);
  endtask

  task automatic scan_frame();
    for (int v = 0; v < 480; v++)
      scan_line(v, v inside {0, 1, 79, 80, 81, 200, 479});
    step(1'b1, 0, 500, 1'b0);
    step(1'b1, 700, 500, 1'b0);
    step(1'b1, 0, 480, 1'b0);
    step(1'b1, 639, 520, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) map_mem[i] = 2'($urandom_range(0, 3));
    map_mem[0] = 2'd1;
    map_mem[1] = 2'd2;
    map_mem[2] = 2'd0;
    map_mem[3] = 2'd3;
    locked = 1'b0;
    k_pix = 0;
    r_line = 0;
    e1 = '{default: 0};
    e2 = '{default: 0};
    e3 = '{default: 0};
    bus.pix_en = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    rst = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 1'b1);
    // Unlocked captures must stay invalid.
    step(1'b1, 10, 10, 1'b0);
    step(1'b1, 0, 5, 1'b0);
    step(1'b1, 639, 5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0);

    scan_frame();
    scan_frame();

    // Reset in the middle of line 200, then stay unlocked until the next frame start.
    for (int v = 0; v < 200; v++) scan_line(v, 1'b0);
    for (int h = 0; h < 100; h++) step(1'b1, h, 200, 1'b0);
    step(1'b1, 100, 200, 1'b1);
    for (int h = 101; h < 110; h++) step(1'b1, h, 200, 1'b0);
    for (int v = 201; v < 206; v++) scan_line(v, 1'b0);
    scan_frame();

    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/maze_tile_scanner.md
# maze_tile_scanner

Scan-order tile addresser and pixel compositor between the VGA timing generator and the per-tile graphic ROMs (wall box, pellet). For every active display pixel it tracks the maze tile column/row and the in-tile offset with counters, fetches the tile type from the synchronous maze map RAM, drives the relative x/y into the combinational tile graphic ROMs, and registers the selected 8-bit colour for the VGA output stage. No dividers: all tile arithmetic is incremental.

## Interface
- PIXELS_WIDTH, 80, tile edge in pixels (square tiles)
- REL_BITS, 7, width of in-tile offset
- PIXEL_COLOR_BITS, 8, colour width (BBGGGRRR)
- MAP_COLS, 8, tiles per row; MAP_ROWS, 6, tile rows
- ADDR_BITS, 6, map address width (>= clog2(MAP_COLS*MAP_ROWS))
- H_ACTIVE, 640; V_ACTIVE, 480, visible area
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; hcount/vcount valid this cycle
- hcount  in  10  current horizontal pixel
- vcount  in  10  current vertical line
- map_addr  out  ADDR_BITS  tile map read address (row*MAP_COLS+col)
- map_data  in  2  tile type, returned 1 clk after map_addr (0 empty, 1 wall, 2 pellet, 3 reserved)
- rel_x, rel_y  out  REL_BITS  in-tile offset to graphic ROMs
- wall_pixel  in  PIXEL_COLOR_BITS  wall ROM output for rel_x/rel_y (combinational)
- pellet_pixel  in  PIXEL_COLOR_BITS  pellet ROM output (combinational)
- pixel_out  out  PIXEL_COLOR_BITS  composed colour
- pixel_valid  out  1  pixel_out corresponds to an active, locked pixel

## Operation
- Trackers: x_off/col (horizontal), y_off/row (vertical), plus frame_locked flag.
- Capture (cycle with pix_en=1): if hcount==0, captured x_off=0, col=0; else tracker values. Active = hcount<H_ACTIVE && vcount<V_ACTIVE && frame_locked (or vcount==0 && hcount==0, which sets lock).
- Horizontal advance on each active capture: x_off+1, wrapping to 0 at PIXELS_WIDTH with col+1. col saturates at MAP_COLS; col==MAP_COLS marks out-of-map.
- Vertical: at pix_en && hcount==H_ACTIVE-1 && vcount<V_ACTIVE, y_off+1, wrap at PIXELS_WIDTH with row+1, row saturates at MAP_ROWS. At pix_en && hcount==0 && vcount==0: y_off=0, row=0, frame_locked=1.
- Stage 1 (regs): map_addr, x_off, y_off, active, oob (col>=MAP_COLS or row>=MAP_ROWS). map_addr=0 when oob or inactive.
- Stage 2 (regs): rel_x, rel_y, active, oob delayed; map_data sampled here as tile type.
- Stage 3 (regs): pixel_out = !active ? 0 : oob ? 0 : type==1 ? wall_pixel : type==2 ? pellet_pixel : 0. pixel_valid = active.
- Pipeline shifts every clk; pix_en=0 cycles inject active=0 bubbles.

## Timing
- Latency: capture at cycle N -> map_addr at N+1, rel_x/rel_y at N+2, pixel_out/pixel_valid at N+3. Fixed, independent of pix_en spacing (pix_en may be every clk).
- Reset: all outputs 0 (map_addr, rel_x, rel_y, pixel_out, pixel_valid), trackers 0, frame_locked 0.
- Reset mid-frame: pixel_valid stays 0 until the next hcount==0 && vcount==0 capture; first valid pixel 3 clk after it.
- hcount==0 force and end-of-line vertical advance never coincide (H_ACTIVE>1); vcount>=V_ACTIVE freezes vertical trackers.
- Tile boundary: pixel at x_off=PIXELS_WIDTH-1 uses old col; next pixel uses col+1, x_off=0.

## Test plan
- Reset then frame start (hcount=0,vcount=0, pix_en every clk): map_addr=0 at N+1, rel_x=0/rel_y=0 at N+2, pixel_valid=1 at N+3.
- Horizontal wrap: pixels 79 and 80 of line 0 -> rel_x 79 then 0, map_addr 0 then 1; pixel 639 -> map_addr 7.
- Vertical wrap: line 80, hcount 0 -> rel_y=0, map_addr=8; line 479 -> rel_y=79, row 5, map_addr 40..47.
- Compose: map_data 1/2/0/3 with wall_pixel=8'hC0, pellet_pixel=8'hFF -> pixel_out C0/FF/00/00.
- Blanking: hcount=700 or vcount=500 -> pixel_valid=0, pixel_out=0; pix_en gaps of 3 clk keep latency 3 clk.
- rst asserted at line 200: outputs 0 next clk; no valid pixel until next (0,0) capture, then normal rel_x/rel_y from 0.
